imm_gen_stage: RTL and testbench

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

---
 rtl/imm_gen_pkg.sv | 55 +++++
 rtl/imm_fmt_dec.sv | 106 ++++++++++
 rtl/imm_gen_stage.sv | 101 ++++++++++
 tb/tb_imm_gen_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pkg
// Purpose  : Shared op encodings, opcode constants and immediate field widths.
// Revision : 1.0 - initial release
// ============================================================================
package imm_gen_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_I    = 4'd1,
    OP_S    = 4'd2,
    OP_B    = 4'd3,
    OP_J    = 4'd4,
    OP_U    = 4'd5,
    OP_CSR  = 4'd6,
    OP_AUTO = 4'd7,
    OP_CI   = 4'd8,
    OP_CIW  = 4'd9,
    OP_CL   = 4'd10,
    OP_CS   = 4'd11,
    OP_CSS  = 4'd12,
    OP_CB   = 4'd13,
    OP_CJ   = 4'd14,
    OP_RSVD = 4'd15
  } imm_op_e;

  localparam int c_op_enc_w = 4;

  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_system = 7'b1110011;

  localparam int c_imm_i_w   = 12;
  localparam int c_imm_s_w   = 12;
  localparam int c_imm_b_w   = 13;
  localparam int c_imm_j_w   = 21;
  localparam int c_imm_u_w   = 32;
  localparam int c_imm_csr_w = 5;
  localparam int c_imm_ci_w  = 6;
  localparam int c_imm_ciw_w = 10;
  localparam int c_imm_cl_w  = 7;
  localparam int c_imm_cs_w  = 7;
  localparam int c_imm_css_w = 8;
  localparam int c_imm_cb_w  = 9;
  localparam int c_imm_cj_w  = 12;

endpackage
`default_nettype wire

// File: rtl/imm_fmt_dec.sv
`default_nettype none
// ============================================================================
// Module   : imm_fmt_dec
// Purpose  : Combinational immediate decode for base, CSR, AUTO and RVC formats.
//            RVC formats are built only when IMM_GEN_STAGE_RVC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module imm_fmt_dec
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic [31:0]     inst,
  input  logic [OP_W-1:0] op,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [OP_W+3:0] w_op_ext;
  logic            w_op_hi;
  imm_op_e         w_op;
  imm_op_e         w_fmt;

  logic [c_imm_i_w-1:0]   w_imm_i;
  logic [c_imm_s_w-1:0]   w_imm_s;
  logic [c_imm_b_w-1:0]   w_imm_b;
  logic [c_imm_j_w-1:0]   w_imm_j;
  logic [c_imm_u_w-1:0]   w_imm_u;
  logic [c_imm_csr_w-1:0] w_imm_csr;

  // Op bits above the 4-bit encoding make the op reserved.
  assign w_op_ext = {4'b0, op};
  assign w_op_hi  = |w_op_ext[OP_W+3:c_op_enc_w];
  assign w_op     = imm_op_e'(w_op_ext[c_op_enc_w-1:0]);

  assign w_imm_i   = inst[31:20];
  assign w_imm_s   = {inst[31:25], inst[11:7]};
  assign w_imm_b   = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_j   = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign w_imm_u   = {inst[31:12], 12'b0};
  assign w_imm_csr = inst[19:15];

`ifdef IMM_GEN_STAGE_RVC_EN
  logic [c_imm_ci_w-1:0]  w_imm_ci;
  logic [c_imm_ciw_w-1:0] w_imm_ciw;
  logic [c_imm_cl_w-1:0]  w_imm_cl;
  logic [c_imm_cs_w-1:0]  w_imm_cs;
  logic [c_imm_css_w-1:0] w_imm_css;
  logic [c_imm_cb_w-1:0]  w_imm_cb;
  logic [c_imm_cj_w-1:0]  w_imm_cj;

  assign w_imm_ci  = {inst[12], inst[6:2]};
  assign w_imm_ciw = {inst[10:7], inst[12:11], inst[5], inst[6], 2'b00};
  assign w_imm_cl  = {inst[5], inst[12:10], inst[6], 2'b00};
  assign w_imm_cs  = {inst[5], inst[12:10], inst[6], 2'b00};
  assign w_imm_css = {inst[8:7], inst[12:9], 2'b00};
  assign w_imm_cb  = {inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
  assign w_imm_cj  = {inst[12], inst[8], inst[10:9], inst[6], inst[7], inst[2],
                      inst[11], inst[5:3], 1'b0};
`endif

  // AUTO resolves to a concrete format; unknown opcodes become reserved.
  always_comb begin
    w_fmt = w_op;
    if (w_op_hi) begin
      w_fmt = OP_RSVD;
    end else if (w_op == OP_AUTO) begin
      case (inst[6:0])
        c_opc_op_imm, c_opc_load, c_opc_jalr: w_fmt = OP_I;
        c_opc_store:                          w_fmt = OP_S;
        c_opc_branch:                         w_fmt = OP_B;
        c_opc_jal:                            w_fmt = OP_J;
        c_opc_lui, c_opc_auipc:               w_fmt = OP_U;
        c_opc_system:                         w_fmt = inst[14] ? OP_CSR : OP_I;
        default:                              w_fmt = OP_RSVD;
      endcase
    end
  end

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (w_fmt)
      OP_NONE: imm = '0;
      OP_I:    imm = XLEN'($signed(w_imm_i));
      OP_S:    imm = XLEN'($signed(w_imm_s));
      OP_B:    imm = XLEN'($signed(w_imm_b));
      OP_J:    imm = XLEN'($signed(w_imm_j));
      OP_U:    imm = XLEN'($signed(w_imm_u));
      OP_CSR:  imm = XLEN'(w_imm_csr);
`ifdef IMM_GEN_STAGE_RVC_EN
      OP_CI:   imm = XLEN'($signed(w_imm_ci));
      OP_CIW:  imm = XLEN'(w_imm_ciw);
      OP_CL:   imm = XLEN'(w_imm_cl);
      OP_CS:   imm = XLEN'(w_imm_cs);
      OP_CSS:  imm = XLEN'(w_imm_css);
      OP_CB:   imm = XLEN'($signed(w_imm_cb));
      OP_CJ:   imm = XLEN'($signed(w_imm_cj));
`endif
      default: err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_stage
// Purpose  : Registered immediate generator with a one-entry skid buffer.
//            Define IMM_GEN_STAGE_RVC_EN to enable RVC immediate formats.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OP_W  = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic [XLEN-1:0]  w_dec_imm;
  logic             w_dec_err;
  logic             w_in_xfer;
  logic             w_out_free;

  logic             r_in_ready;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_err;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_err;

  imm_fmt_dec #(
    .XLEN (XLEN),
    .OP_W (OP_W)
  ) u_dec (
    .inst (in_inst),
    .op   (in_op),
    .imm  (w_dec_imm),
    .err  (w_dec_err)
  );

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

  // r_in_ready low is the skid-occupied flag; no separate skid valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_tag   <= '0;
      r_out_err   <= 1'b0;
      r_skid_imm  <= '0;
      r_skid_tag  <= '0;
      r_skid_err  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (w_out_free) begin
      if (!r_in_ready) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= r_skid_imm;
        r_out_tag   <= r_skid_tag;
        r_out_err   <= r_skid_err;
        r_in_ready  <= 1'b1;
      end else begin
        r_out_valid <= w_in_xfer;
        if (w_in_xfer) begin
          r_out_imm <= w_dec_imm;
          r_out_tag <= in_tag;
          r_out_err <= w_dec_err;
        end
      end
    end else if (w_in_xfer) begin
      r_skid_imm <= w_dec_imm;
      r_skid_tag <= in_tag;
      r_skid_err <= w_dec_err;
      r_in_ready <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_imm   = r_out_imm;
  assign out_tag   = r_out_tag;
  assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_stage
// Purpose  : Self-checking bench for imm_gen_stage at XLEN=32 and XLEN=64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [3:0]  in_op;
  logic [7:0]  in_tag;
  logic        flush;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_err_a;
  logic [31:0] out_imm_a;
  logic [7:0]  out_tag_a;
  logic        in_ready_b, out_valid_b, out_err_b;
  logic [63:0] out_imm_b;
  logic [7:0]  out_tag_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .OP_W(4), .TAG_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst(in_inst), .in_op(in_op), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
    .out_tag(out_tag_a), .out_err(out_err_a)
  );

  imm_gen_stage #(.XLEN(64), .OP_W(4), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst(in_inst), .in_op(in_op), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
    .out_tag(out_tag_b), .out_err(out_err_b)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] inst;
    logic [63:0] imm;
    logic        err;
  } vec_t;

  typedef struct {
    logic [7:0]  tag;
    logic [63:0] imm;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  logic [6:0] opcs [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                            7'h6F, 7'h37, 7'h17, 7'h73, 7'h33};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] tag,
                         input logic [63:0] imm, input logic err);
    chk({name, ".valid64"}, 64'(out_valid_b), 64'd1);
    chk({name, ".tag64"},   64'(out_tag_b),   64'(tag));
    chk({name, ".imm64"},   out_imm_b,        imm);
    chk({name, ".err64"},   64'(out_err_b),   64'(err));
    chk({name, ".valid32"}, 64'(out_valid_a), 64'd1);
    chk({name, ".tag32"},   64'(out_tag_a),   64'(tag));
    chk({name, ".imm32"},   64'(out_imm_a),   64'(imm[31:0]));
    chk({name, ".err32"},   64'(out_err_a),   64'(err));
  endtask

  task automatic chk_hs(input string name, input logic vld, input logic rdy);
    chk({name, ".out_valid64"}, 64'(out_valid_b), 64'(vld));
    chk({name, ".in_ready64"},  64'(in_ready_b),  64'(rdy));
    chk({name, ".out_valid32"}, 64'(out_valid_a), 64'(vld));
    chk({name, ".in_ready32"},  64'(in_ready_a),  64'(rdy));
  endtask

  task automatic chk_zero(input string name);
    chk_hs(name, 1'b0, 1'b1);
    chk({name, ".imm64"}, out_imm_b, 64'd0);
    chk({name, ".tag64"}, 64'(out_tag_b), 64'd0);
    chk({name, ".err64"}, 64'(out_err_b), 64'd0);
    chk({name, ".imm32"}, 64'(out_imm_a), 64'd0);
    chk({name, ".tag32"}, 64'(out_tag_a), 64'd0);
    chk({name, ".err32"}, 64'(out_err_a), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint fld(input logic [31:0] x, input int hi, input int lo);
    logic [31:0] m;
    m = (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    return longint'(m);
  endfunction

  // Reference: immediate value as signed arithmetic on instruction fields.
  function automatic logic [64:0] ref_imm(input logic [3:0] op, input logic [31:0] x);
    int     fmt;
    longint v;
    logic   e;
    fmt = int'(op);
    v = 0;
    e = 1'b0;
    if (fmt == 7) begin
      case (x[6:0])
        7'h13, 7'h03, 7'h67: fmt = 1;
        7'h23:               fmt = 2;
        7'h63:               fmt = 3;
        7'h6F:               fmt = 4;
        7'h37, 7'h17:        fmt = 5;
        7'h73:               fmt = x[14] ? 6 : 1;
        default:             fmt = 15;
      endcase
    end
    case (fmt)
      0: v = 0;
      1: v = -fld(x,31,31)*2048 + fld(x,30,20);
      2: v = -fld(x,31,31)*2048 + fld(x,30,25)*32 + fld(x,11,7);
      3: v = -fld(x,31,31)*4096 + fld(x,7,7)*2048 + fld(x,30,25)*32 + fld(x,11,8)*2;
      4: v = -fld(x,31,31)*1048576 + fld(x,19,12)*4096 + fld(x,20,20)*2048 + fld(x,30,21)*2;
      5: v = -fld(x,31,31)*64'sd2147483648 + fld(x,30,12)*4096;
      6: v = fld(x,19,15);
`ifdef IMM_GEN_STAGE_RVC_EN
      8:  v = -fld(x,12,12)*32 + fld(x,6,2);
      9:  v = fld(x,10,7)*64 + fld(x,12,11)*16 + fld(x,5,5)*8 + fld(x,6,6)*4;
      10, 11: v = fld(x,5,5)*64 + fld(x,12,10)*8 + fld(x,6,6)*4;
      12: v = fld(x,8,7)*64 + fld(x,12,9)*4;
      13: v = -fld(x,12,12)*256 + fld(x,6,5)*64 + fld(x,2,2)*32 + fld(x,11,10)*8 + fld(x,4,3)*2;
      14: v = -fld(x,12,12)*2048 + fld(x,8,8)*1024 + fld(x,10,9)*256 + fld(x,6,6)*128
              + fld(x,7,7)*64 + fld(x,2,2)*32 + fld(x,11,11)*16 + fld(x,5,3)*2;
`endif
      default: e = 1'b1;
    endcase
    return {e, 64'(v)};
  endfunction

  task automatic add(input logic [3:0] op, input logic [31:0] x,
                     input logic [63:0] imm, input logic err);
    vec_t t;
    t.op = op; t.inst = x; t.imm = imm; t.err = err;
    vecs.push_back(t);
  endtask

  initial begin
    int lvl;
    logic [64:0] r;
    exp_t e;

    rst_n = 1'b1; in_valid = 1'b0; in_inst = '0; in_op = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b0;

    add(4'd1,  32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    add(4'd3,  32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    add(4'd7,  32'h123450B7, 64'h0000000012345000, 1'b0);
    add(4'd7,  32'h80000037, 64'hFFFFFFFF80000000, 1'b0);
    add(4'd7,  32'h0000007F, 64'h0,                1'b1);
    add(4'd0,  32'h12345678, 64'h0,                1'b0);
    add(4'd15, 32'hFFF00093, 64'h0,                1'b1);
    add(4'd6,  32'h000F8000, 64'd31,               1'b0);
    add(4'd2,  32'hFE000FA3, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    add(4'd4,  32'h0040006F, 64'd4,                1'b0);
    add(4'd7,  32'h000FD073, 64'd31,               1'b0);
    add(4'd7,  32'h80002073, 64'hFFFFFFFFFFFFF800, 1'b0);
    add(4'd7,  32'h00112223, 64'd4,                1'b0);
`ifdef IMM_GEN_STAGE_RVC_EN
    add(4'd8,  32'h000050FD, 64'hFFFFFFFFFFFFFFFF, 1'b0);
`else
    add(4'd8,  32'h000050FD, 64'h0,                1'b1);
`endif

    #1 rst_n = 1'b0;
    #11;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Back-to-back vectors: each result must appear exactly one cycle later.
    for (int i = 0; i <= vecs.size(); i++) begin
      if (i > 0) chk_out($sformatf("vec%0d", i - 1), 8'(i + 15), vecs[i-1].imm, vecs[i-1].err);
      else chk_hs("first_ready", 1'b0, 1'b1);
      if (i < vecs.size()) begin
        in_valid = 1'b1; in_op = vecs[i].op; in_inst = vecs[i].inst; in_tag = 8'(i + 16);
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    chk_hs("drain", 1'b0, 1'b1);

    // Backpressure: tags 1,2 accepted, 3 stalls, order and data held.
    out_ready = 1'b0; in_valid = 1'b1; in_op = 4'd1;
    in_tag = 8'd1; in_inst = 32'h00100093;
    step();
    chk_hs("bp_t1", 1'b1, 1'b1);
    chk_out("bp_t1", 8'd1, 64'd1, 1'b0);
    in_tag = 8'd2; in_inst = 32'h00200093;
    step();
    chk_hs("bp_full", 1'b1, 1'b0);
    chk_out("bp_hold1", 8'd1, 64'd1, 1'b0);
    in_tag = 8'd3; in_inst = 32'h00300093;
    step();
    chk_hs("bp_stall", 1'b1, 1'b0);
    chk_out("bp_hold2", 8'd1, 64'd1, 1'b0);
    out_ready = 1'b1;
    step();
    chk_hs("bp_release", 1'b1, 1'b1);
    chk_out("bp_t2", 8'd2, 64'd2, 1'b0);
    step();
    chk_out("bp_t3", 8'd3, 64'd3, 1'b0);
    in_valid = 1'b0;
    step();
    chk_hs("bp_empty", 1'b0, 1'b1);

    // Flush with both entries full and an input offered.
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 8'd5; in_inst = 32'h00500093;
    step();
    in_tag = 8'd6; in_inst = 32'h00600093;
    step();
    chk_hs("fl_full", 1'b1, 1'b0);
    in_tag = 8'd7; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk_hs("fl_after", 1'b0, 1'b1);
    out_ready = 1'b1;
    step();
    chk_hs("fl_quiet1", 1'b0, 1'b1);
    step();
    chk_hs("fl_quiet2", 1'b0, 1'b1);
    in_valid = 1'b1; in_tag = 8'd8; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk_hs("fl_drop", 1'b0, 1'b1);
    in_valid = 1'b1; in_tag = 8'd9; in_inst = 32'h00900093;
    step();
    in_valid = 1'b0;
    chk_out("fl_post", 8'd9, 64'd9, 1'b0);
    step();

    // Asynchronous reset in the middle of a cycle with both entries full.
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 8'd10; in_inst = 32'hFFF00093;
    step();
    in_tag = 8'd11;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Randomized traffic against the queue-based reference.
    sb.delete();
    for (int n = 0; n < 500; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
      in_op     = 4'($urandom_range(0, 15));
      in_inst   = $urandom();
      if (in_op == 4'd7 && $urandom_range(0, 3) != 0) in_inst[6:0] = opcs[$urandom_range(0, 9)];
      in_tag    = 8'($urandom());
      @(negedge clk);
      lvl = sb.size();
      chk_hs($sformatf("rnd%0d", n), lvl > 0, lvl < 2);
      if (lvl > 0) begin
        chk("rnd.tag64", 64'(out_tag_b), 64'(sb[0].tag));
        chk("rnd.imm64", out_imm_b, sb[0].imm);
        chk("rnd.err64", 64'(out_err_b), 64'(sb[0].err));
        chk("rnd.tag32", 64'(out_tag_a), 64'(sb[0].tag));
        chk("rnd.imm32", 64'(out_imm_a), 64'(sb[0].imm[31:0]));
        chk("rnd.err32", 64'(out_err_a), 64'(sb[0].err));
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (lvl > 0 && out_ready) void'(sb.pop_front());
        if (in_valid && lvl < 2) begin
          r = ref_imm(in_op, in_inst);
          e.tag = in_tag; e.imm = r[63:0]; e.err = r[64];
          sb.push_back(e);
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
